// File: rtl/soma_bcd_7seg_pkg.sv
// soma_bcd_7seg_pkg: shared state enum, segment codes and defaults for the BCD/7-seg converter
package soma_bcd_7seg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEF_IN_W = 7;
  localparam int DEF_N_DIG = 3;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/soma_bcd_7seg_seg7_enc.sv
// soma_bcd_7seg_seg7_enc: one BCD digit plus blank flag to gfedcba segments
module soma_bcd_7seg_seg7_enc
  import soma_bcd_7seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] d,
  input  logic       blank,
  output logic [6:0] seg
);
  logic [6:0] lo;
  assign lo = blank ? SEG_BLANK : seg_code(d);
  assign seg = SEG_ACTIVE_LOW ? lo : ~lo;
endmodule

// File: rtl/soma_bcd_7seg.sv
// soma_bcd_7seg: sequential double-dabble binary-to-BCD with blanked 7-segment outputs
module soma_bcd_7seg
  import soma_bcd_7seg_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int N_DIG = DEF_N_DIG,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_bin,
  output logic                 out_valid,
  output logic [4*N_DIG-1:0]   bcd,
  output logic [7*N_DIG-1:0]   hex
);
  localparam int CW = $clog2(IN_W + 1);
  localparam logic [6:0] ZERO = SEG_ACTIVE_LOW ? SEG_0 : ~SEG_0;
  localparam logic [6:0] BLNK = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [7*N_DIG-1:0] RST_HEX = {{(N_DIG-1){BLNK}}, ZERO};
  state_t state;
  logic [IN_W-1:0] sr;
  logic [4*N_DIG-1:0] scr, adj, nxt;
  logic [CW-1:0] cnt;
  logic [N_DIG-1:0] blank;
  logic [7*N_DIG-1:0] enc;
  assign in_ready = state == IDLE;
  always_comb begin
    adj = scr;
    for (int i = 0; i < N_DIG; i++)
      adj[4*i+:4] = scr[4*i+:4] >= 4'd5 ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
  end
  assign nxt = {adj[4*N_DIG-2:0], sr[IN_W-1]};
  // encoders look at the value this iteration produces so hex lands with bcd
  for (genvar g = 0; g < N_DIG; g++) begin : g_dig
    assign blank[g] = (g != 0) && (nxt[4*N_DIG-1:4*g] == '0);
    soma_bcd_7seg_seg7_enc #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc (
      .d(nxt[4*g+:4]),
      .blank(blank[g]),
      .seg(enc[7*g+:7])
    );
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      out_valid <= 1'b0;
      bcd <= '0;
      hex <= RST_HEX;
      sr <= '0;
      scr <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sr <= in_bin;
          scr <= '0;
          cnt <= CW'(IN_W);
          state <= SHIFT;
        end
        SHIFT: begin
          scr <= nxt;
          sr <= sr << 1;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd <= nxt;
            hex <= enc;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soma_bcd_7seg.sv
// tb_soma_bcd_7seg: random and directed stimulus checked every cycle against a decimal-arithmetic model
module tb_soma_bcd_7seg;
  localparam int IN_W = 7;
  localparam int N_DIG = 3;
  localparam logic [6:0] BL = 7'b1111111;
  logic clk = 1'b0, clr = 1'b0, in_valid = 1'b0, in_ready, out_valid;
  logic [IN_W-1:0] in_bin = '0;
  logic [4*N_DIG-1:0] bcd;
  logic [7*N_DIG-1:0] hex;
  int total = 0, bad = 0;
  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int since = -1, cyc = 0, last = -1, val = 0;
  bit armed = 0, hold = 0;
  logic e_ov = 1'b0;
  logic [4*N_DIG-1:0] e_bcd = '0;
  logic [7*N_DIG-1:0] e_hex = '0;

  soma_bcd_7seg #(.IN_W(IN_W), .N_DIG(N_DIG), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_bin(in_bin), .out_valid(out_valid), .bcd(bcd), .hex(hex)
  );

  always #5 clk = ~clk;

  function automatic logic [4*N_DIG-1:0] mb(input int v);
    int p = 1;
    mb = '0;
    for (int i = 0; i < N_DIG; i++) begin
      mb[4*i+:4] = 4'((v / p) % 10);
      p *= 10;
    end
  endfunction

  function automatic logic [7*N_DIG-1:0] mh(input int v);
    int p = 1;
    mh = '0;
    for (int i = 0; i < N_DIG; i++) begin
      mh[7*i+:7] = (i > 0 && v < p) ? BL : segtab[(v / p) % 10];
      p *= 10;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // timeline model: result appears IN_W edges after accept, idle again one edge later
  always @(posedge clk) begin
    cyc++;
    if (clr) begin
      since = -1; e_ov = 1'b0; e_bcd = '0; e_hex = mh(0); armed = 1;
    end else if (since < 0) begin
      if (in_valid) begin since = 0; val = int'(in_bin); end
    end else begin
      since++;
      if (since == IN_W) begin
        e_bcd = mb(val); e_hex = mh(val); e_ov = 1'b1;
      end else if (since == IN_W + 1) begin
        e_ov = 1'b0; since = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(since < 0));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("bcd", 32'(bcd), 32'(e_bcd));
      chk("hex", 32'(hex), 32'(e_hex));
    end
    if (!hold) last = -1;
    else if (in_valid && in_ready) begin
      if (last >= 0) chk("accept_gap", 32'(cyc - last), 32'd9);
      last = cyc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic convert(input int v);
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; in_bin = IN_W'(v);
    step();
    in_valid = 1'b0; in_bin = IN_W'($urandom);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    chk("model_bcd126", 32'(mb(126)), 32'h126);
    chk("model_hex126", 32'(mh(126)), 32'({7'b1111001, 7'b0100100, 7'b0000010}));
    chk("model_hex5", 32'(mh(5)), 32'({BL, BL, 7'b0010010}));
    chk("model_hex100", 32'(mh(100)), 32'({7'b1111001, 7'b1000000, 7'b1000000}));
    clr = 1'b1; step(); step(); clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h000);
    chk("rst_hex", 32'(hex), 32'({BL, BL, 7'b1000000}));
    step();
    convert(126);
    chk("lit_bcd126", 32'(bcd), 32'h126);
    chk("lit_hex126", 32'(hex), 32'({7'b1111001, 7'b0100100, 7'b0000010}));
    convert(5);
    chk("lit_bcd5", 32'(bcd), 32'h005);
    chk("lit_hex5", 32'(hex), 32'({BL, BL, 7'b0010010}));
    convert(100);
    chk("lit_bcd100", 32'(bcd), 32'h100);
    chk("lit_hex1_100", 32'(hex[13:7]), 32'(7'b1000000));
    // continuous valid with changing data
    step(); step();
    hold = 1; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin in_bin = IN_W'($urandom); step(); end
    in_valid = 1'b0; hold = 0;
    for (int i = 0; i < 12; i++) step();
    // abort on third SHIFT cycle
    in_valid = 1'b1; in_bin = IN_W'(99); step();
    in_valid = 1'b0; step(); step();
    clr = 1'b1; step(); clr = 1'b0;
    @(negedge clk);
    chk("abort_bcd", 32'(bcd), 32'h000);
    chk("abort_hex", 32'(hex), 32'({BL, BL, 7'b1000000}));
    chk("abort_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) step();
    convert(42);
    chk("lit_bcd42", 32'(bcd), 32'h042);
    chk("lit_hex42", 32'(hex), 32'({BL, 7'b0011001, 7'b0100100}));
    for (int v = 0; v < 128; v++) begin
      convert(v);
      for (int k = $urandom_range(0, 2); k > 0; k--) step();
    end
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom);
      in_bin = IN_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/soma_bcd_7seg.md
Name: soma_bcd_7seg

Overview:
- Downstream consumer of the 7-bit counter sum (range 0..126).
- Converts a binary sum to BCD with a sequential double-dabble (shift-add-3) engine, one iteration per clock.
- Drives the board's 7-segment digits with leading-zero blanking.
- Uses a valid/ready handshake on the input and a one-cycle done pulse on the output, so the counter/adder stage can be sampled on demand.

Parameters:
- IN_W, 7: binary input width. Constraint: 2^IN_W-1 < 10^N_DIG.
- N_DIG, 3: number of BCD digits / 7-seg displays.
- SEG_ACTIVE_LOW, 1: 1 means segment on = 0 (board default); 0 inverts all segment outputs.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- in_valid  in  1  in_bin holds a value to convert.
- in_ready  out  1  block can accept; high only in IDLE.
- in_bin  in  IN_W  unsigned binary value (the adder's soma).
- out_valid  out  1  one-cycle pulse: new bcd/hex result written.
- bcd  out  4*N_DIG  packed BCD; digit 0 (units) in bits [3:0].
- hex  out  7*N_DIG  packed segments; digit i in [7i+6:7i]; per-digit bit order gfedcba (bit6=g, bit0=a).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on clr.
- clr has priority over every other event, including in_valid on the same edge.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, bcd=0.
  - hex digit0 = code '0' (7'b1000000 when active-low); all other digits blank (7'b1111111 when active-low).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On an edge with in_valid&&in_ready (accept edge T0):
    - load shift reg = in_bin;
    - clear BCD scratch;
    - iteration counter = IN_W;
    - go to SHIFT.
  - SHIFT: in_ready=0; in_valid and in_bin are ignored. Each edge performs one iteration:
    - add 3 to every scratch digit >= 5;
    - shift {scratch, shift reg} left by 1;
    - decrement the counter.
  - Completion edge (T0+IN_W, i.e. the IN_W-th iteration):
    - write the final scratch value to bcd and the encoded digits to hex;
    - out_valid<=1;
    - go to DONE.
  - DONE: out_valid=1 and in_ready=0 for exactly this one cycle. Next edge: out_valid<=0, go to IDLE.
- Timing:
  - Latency: out_valid rises at edge T0+IN_W (T0+7 by default).
  - Throughput: next accept no earlier than edge T0+IN_W+2 (period 9 cycles by default).
- bcd and hex hold the last result until the next completion. They do not change during SHIFT.
- Leading-zero blanking:
  - digit i>0 is blank iff it and all higher digits are 0;
  - digit 0 is never blanked.
- Segment encoder: digit codes 10..15 cannot occur from a correct conversion; the encoder maps them to blank.
- clr mid-conversion (SHIFT or DONE):
  - conversion aborted, no out_valid is produced;
  - all outputs return to reset values on that edge.
- in_valid held high continuously: a new value is accepted on every IDLE cycle (back-to-back at the throughput limit).

Decomposition:
- Shared package holds:
  - state enum (IDLE/SHIFT/DONE);
  - SEG_* digit constants '0'..'9' and SEG_BLANK, in gfedcba active-low form;
  - default IN_W/N_DIG.
- One natural sub-module: seg7_enc.
  - Combinational: 4-bit digit plus blank input -> 7 segments.
  - Applies SEG_ACTIVE_LOW inversion.
  - Instantiated N_DIG times.

Test Plan:
1. Reset: clr high 2 cycles, then low -> in_ready=1, out_valid=0, bcd=12'h000, hex[6:0]=7'b1000000, hex[13:7]=hex[20:14]=7'b1111111.
2. in_bin=126, in_valid for 1 cycle -> out_valid is a single pulse at edge T0+7. Result: bcd=12'h126; hex2=7'b1111001, hex1=7'b0100100, hex0=7'b0000010. in_ready low from T0 until T0+8.
3. Leading-zero blanking:
   - in_bin=5 -> bcd=12'h005; hex2=hex1=blank; hex0=7'b0010010.
   - in_bin=100 -> bcd=12'h100; hex1=7'b1000000 (not blanked).
4. in_valid held high while in_bin changes each cycle -> only values present on accept edges are converted; accepts exactly 9 cycles apart; the outputs for each accept match its value.
5. clr pulsed on the 3rd SHIFT cycle of converting 99 -> no out_valid; outputs at reset values. A following conversion of 42 yields bcd=12'h042 with hex2 blank.
6. Exhaustive sweep in_bin=0..127 against a behavioural model -> all bcd/hex match; exactly one out_valid per accept.
